// File: rtl/note_lane_scheduler_pkg.sv
// rtl/note_lane_scheduler_pkg.sv - shared note-lane constants, FSM encoding and slot indexing
package note_lane_scheduler_pkg;

    localparam int DEF_NUM_LANES    = 4;
    localparam int DEF_MAX_NOTES    = 4;
    localparam int DEF_POS_W        = 11;
    localparam int VIDEO_HEIGHT     = 480;
    localparam int DEF_RETIRE_Y     = VIDEO_HEIGHT;
    localparam int DEF_SPAWN_Y      = -50;
    localparam int DEF_NOTE_SPEED   = 1;
    localparam int DEF_SPAWN_FRAMES = 120;
    localparam int DEF_CHART_LEN    = 63;
    localparam int DEF_CHART_AW     = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_MOVE,
        ST_FETCH,
        ST_SPAWN,
        ST_DONE
    } state_t;

    // Flat slot number shared with the renderer: lane-major, slot-minor
    function automatic int slot_idx(input int lane, input int slot, input int per_lane);
        return lane * per_lane + slot;
    endfunction

endpackage

// File: rtl/first_free_slot.sv
// rtl/first_free_slot.sv - lowest-index free slot finder for one lane
module first_free_slot #(
    parameter int MAX_NOTES = 4,
    parameter int IDX_W     = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1
) (
    input  logic [MAX_NOTES-1:0] valid,
    output logic [IDX_W-1:0]     free_idx,
    output logic                 full
);

    // Scan downward so the last hit is the lowest free index
    always_comb begin
        free_idx = '0;
        for (int i = MAX_NOTES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    assign full = &valid;

endmodule

// File: rtl/note_lane_scheduler.sv
// rtl/note_lane_scheduler.sv - chart-driven note spawner and per-frame scroller
module note_lane_scheduler
    import note_lane_scheduler_pkg::*;
#(
    parameter int NUM_LANES    = DEF_NUM_LANES,
    parameter int MAX_NOTES    = DEF_MAX_NOTES,
    parameter int POS_W        = DEF_POS_W,
    parameter int NOTE_SPEED   = DEF_NOTE_SPEED,
    parameter int SPAWN_Y      = DEF_SPAWN_Y,
    parameter int RETIRE_Y     = DEF_RETIRE_Y,
    parameter int SPAWN_FRAMES = DEF_SPAWN_FRAMES,
    parameter int CHART_LEN    = DEF_CHART_LEN,
    parameter int CHART_AW     = DEF_CHART_AW
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic                                 frame_tick,
    output logic [CHART_AW-1:0]                  chart_addr,
    input  logic [NUM_LANES-1:0]                 chart_data,
    output logic [NUM_LANES*MAX_NOTES*POS_W-1:0] note_y,
    output logic [NUM_LANES*MAX_NOTES-1:0]       note_valid,
    output logic [NUM_LANES-1:0]                 miss_pulse,
    output logic                                 overflow,
    output logic                                 song_done
);

    localparam int NUM_SLOTS = NUM_LANES * MAX_NOTES;
    localparam int IDX_W     = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1;
    localparam int CNT_W     = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;

    localparam logic signed [POS_W-1:0] SPEED_C    = POS_W'(NOTE_SPEED);
    localparam logic signed [POS_W-1:0] SPAWN_C    = POS_W'(SPAWN_Y);
    localparam logic signed [POS_W-1:0] RETIRE_C   = POS_W'(RETIRE_Y);
    localparam logic [CHART_AW-1:0]     CHART_LEN_C = CHART_AW'(CHART_LEN);
    localparam logic [CNT_W-1:0]        CNT_LAST    = CNT_W'(SPAWN_FRAMES - 1);

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        frame_cnt;
    logic signed [POS_W-1:0] y_q   [NUM_SLOTS];
    logic signed [POS_W-1:0] y_inc [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]    valid_q;
    logic [NUM_SLOTS-1:0]    retire;
    logic [NUM_SLOTS-1:0]    moved_valid;
    logic [NUM_LANES-1:0]    lane_retire;
    logic [NUM_LANES-1:0]    lane_full;
    logic [IDX_W-1:0]        free_idx [NUM_LANES];
    logic                    entries_left;
    logic                    spawn_now;
    logic                    all_retired;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        first_free_slot #(
            .MAX_NOTES (MAX_NOTES),
            .IDX_W     (IDX_W)
        ) u_first_free_slot (
            .valid    (valid_q[l*MAX_NOTES +: MAX_NOTES]),
            .free_idx (free_idx[l]),
            .full     (lane_full[l])
        );
    end

    // Signed compare keeps notes still above the screen (negative y) live
    always_comb begin
        retire      = '0;
        lane_retire = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            y_inc[k]  = y_q[k] + SPEED_C;
            retire[k] = valid_q[k] && (y_inc[k] >= RETIRE_C);
            lane_retire[k / MAX_NOTES] = lane_retire[k / MAX_NOTES] | retire[k];
        end
        moved_valid = valid_q & ~retire;
    end

    assign entries_left = (chart_addr < CHART_LEN_C);
    assign spawn_now    = (frame_cnt == CNT_LAST) && entries_left;
    assign all_retired  = !entries_left && (moved_valid == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) state_nxt = ST_WAIT;
            ST_WAIT:          if (frame_tick) state_nxt = ST_MOVE;
            ST_MOVE: begin
                if (spawn_now) begin
                    state_nxt = ST_FETCH;
                end else if (all_retired) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_FETCH:         state_nxt = ST_SPAWN;
            ST_SPAWN:         state_nxt = ST_WAIT;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= '0;
            chart_addr <= '0;
            frame_cnt  <= '0;
            miss_pulse <= '0;
            overflow   <= 1'b0;
            for (int k = 0; k < NUM_SLOTS; k++) begin
                y_q[k] <= '0;
            end
        end else begin
            miss_pulse <= '0;
            overflow   <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        chart_addr <= '0;
                        frame_cnt  <= '0;
                    end
                end
                ST_MOVE: begin
                    for (int k = 0; k < NUM_SLOTS; k++) begin
                        if (valid_q[k]) begin
                            y_q[k] <= y_inc[k];
                        end
                    end
                    valid_q    <= moved_valid;
                    miss_pulse <= lane_retire;
                    frame_cnt  <= spawn_now ? '0 : frame_cnt + 1'b1;
                end
                ST_SPAWN: begin
                    for (int l = 0; l < NUM_LANES; l++) begin
                        for (int s = 0; s < MAX_NOTES; s++) begin
                            if (chart_data[l] && !lane_full[l] && (IDX_W'(s) == free_idx[l])) begin
                                y_q[slot_idx(l, s, MAX_NOTES)]     <= SPAWN_C;
                                valid_q[slot_idx(l, s, MAX_NOTES)] <= 1'b1;
                            end
                        end
                    end
                    overflow   <= |(chart_data & lane_full);
                    chart_addr <= chart_addr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        note_y = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            note_y[k*POS_W +: POS_W] = y_q[k];
        end
    end

    assign note_valid = valid_q;
    assign song_done  = (state == ST_DONE);

endmodule

// File: tb/tb_note_lane_scheduler.sv
// tb/tb_note_lane_scheduler.sv - directed self-checking bench for note_lane_scheduler
module tb_note_lane_scheduler;

    localparam int NL = 4;
    localparam int MN = 2;
    localparam int PW = 11;
    localparam int AW = 6;

    localparam logic [PW-1:0] Y_M50 = 11'h7CE;
    localparam logic [PW-1:0] Y_M48 = 11'h7D0;
    localparam logic [PW-1:0] Y_M46 = 11'h7D2;
    localparam logic [PW-1:0] Y_479 = 11'h1DF;
    localparam logic [PW-1:0] Y_480 = 11'h1E0;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic                  frame_tick;
    logic [AW-1:0]         chart_addr;
    logic [NL-1:0]         chart_data = '0;
    logic [NL*MN*PW-1:0]   note_y;
    logic [NL*MN-1:0]      note_valid;
    logic [NL-1:0]         miss_pulse;
    logic                  overflow;
    logic                  song_done;

    logic [NL-1:0] rom [64];
    int n_checks = 0;
    int n_fail   = 0;

    note_lane_scheduler #(
        .NUM_LANES    (NL),
        .MAX_NOTES    (MN),
        .POS_W        (PW),
        .NOTE_SPEED   (1),
        .SPAWN_Y      (-50),
        .RETIRE_Y     (480),
        .SPAWN_FRAMES (2),
        .CHART_LEN    (3),
        .CHART_AW     (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .frame_tick (frame_tick),
        .chart_addr (chart_addr),
        .chart_data (chart_data),
        .note_y     (note_y),
        .note_valid (note_valid),
        .miss_pulse (miss_pulse),
        .overflow   (overflow),
        .song_done  (song_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) chart_data <= rom[chart_addr];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] ysl(input int k);
        return note_y[k*PW +: PW];
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        step(4);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic load(input logic [NL-1:0] a, input logic [NL-1:0] b, input logic [NL-1:0] c);
        for (int i = 0; i < 64; i++) rom[i] = '0;
        rom[0] = a;
        rom[1] = b;
        rom[2] = c;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        frame_tick = 1'b0;
        load('0, '0, '0);
        step(2);
        check("rst_valid", 32'(note_valid), 32'h0);
        check("rst_y_zero", 32'(note_y == '0), 32'h1);
        check("rst_addr", 32'(chart_addr), 32'h0);
        check("rst_miss", 32'(miss_pulse), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        check("rst_done", 32'(song_done), 32'h0);
        reset = 1'b0;
        step(1);
        tick();
        check("idle_tick_valid", 32'(note_valid), 32'h0);
        check("idle_tick_addr", 32'(chart_addr), 32'h0);

        // Song A: spawn timing and scrolling
        load(4'b0001, 4'b1010, 4'b0000);
        pulse_start();
        tick();
        check("a_t1_valid", 32'(note_valid), 32'h0);
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        step(2);
        check("a_t2_early_valid", 32'(note_valid), 32'h0);
        step(1);
        check("a_t2_valid", 32'(note_valid), 32'h01);
        check("a_t2_y0", 32'(ysl(0)), 32'(Y_M50));
        check("a_t2_addr", 32'(chart_addr), 32'h1);
        step(1);
        tick();
        tick();
        check("a_t4_valid", 32'(note_valid), 32'h45);
        check("a_t4_y0", 32'(ysl(0)), 32'(Y_M48));
        check("a_t4_y2", 32'(ysl(2)), 32'(Y_M50));
        check("a_t4_y6", 32'(ysl(6)), 32'(Y_M50));
        check("a_t4_addr", 32'(chart_addr), 32'h2);
        check("a_t4_ovf", 32'(overflow), 32'h0);
        tick();
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        step(2);
        reset = 1'b1;
        step(1);
        check("midspawn_rst_valid", 32'(note_valid), 32'h0);
        check("midspawn_rst_addr", 32'(chart_addr), 32'h0);
        check("midspawn_rst_y", 32'(note_y == '0), 32'h1);
        reset = 1'b0;
        step(1);
        tick();
        tick();
        check("post_rst_tick_valid", 32'(note_valid), 32'h0);
        check("post_rst_tick_addr", 32'(chart_addr), 32'h0);
        check("post_rst_done", 32'(song_done), 32'h0);

        // Song C: lane 2 fills, third spawn overflows
        load(4'b0100, 4'b0100, 4'b0100);
        pulse_start();
        repeat (4) tick();
        check("c_t4_valid", 32'(note_valid), 32'h30);
        check("c_t4_ovf", 32'(overflow), 32'h0);
        tick();
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        step(3);
        check("c_ovf_pulse", 32'(overflow), 32'h1);
        check("c_ovf_valid", 32'(note_valid), 32'h30);
        check("c_ovf_y4", 32'(ysl(4)), 32'(Y_M46));
        check("c_ovf_y5", 32'(ysl(5)), 32'(Y_M48));
        check("c_ovf_addr", 32'(chart_addr), 32'h3);
        step(1);
        check("c_ovf_clear", 32'(overflow), 32'h0);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(1);

        // Song B: single note scrolls off the bottom, song ends
        load(4'b0001, 4'b0000, 4'b0000);
        pulse_start();
        repeat (531) tick();
        check("b_pre_valid", 32'(note_valid), 32'h01);
        check("b_pre_y0", 32'(ysl(0)), 32'(Y_479));
        check("b_pre_addr", 32'(chart_addr), 32'h3);
        check("b_pre_done", 32'(song_done), 32'h0);
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        step(1);
        check("b_miss", 32'(miss_pulse), 32'h1);
        check("b_miss_valid", 32'(note_valid), 32'h0);
        check("b_miss_y0_hold", 32'(ysl(0)), 32'(Y_480));
        check("b_done", 32'(song_done), 32'h1);
        step(1);
        check("b_miss_clear", 32'(miss_pulse), 32'h0);
        tick();
        tick();
        check("b_done_valid", 32'(note_valid), 32'h0);
        check("b_done_addr", 32'(chart_addr), 32'h3);
        check("b_done_hold", 32'(song_done), 32'h1);
        check("b_done_miss", 32'(miss_pulse), 32'h0);
        pulse_start();
        check("b_restart_addr", 32'(chart_addr), 32'h0);
        check("b_restart_done", 32'(song_done), 32'h0);
        tick();
        tick();
        check("b_restart_valid", 32'(note_valid), 32'h01);
        check("b_restart_y0", 32'(ysl(0)), 32'(Y_M50));
        check("b_restart_addr1", 32'(chart_addr), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
